// File: rtl/limb_mul_sched_40.sv
// rtl/limb_mul_sched_40.sv - schedules an NLIMB x NLIMB limb multiply over one shared 40x40 multiplier
module limb_mul_sched_40 #(
    parameter int NLIMB   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NLIMB*40-1:0]     op_a,
    input  logic [NLIMB*40-1:0]     op_b,
    output logic                    busy,
    output logic                    done,
    output logic [2*NLIMB*40-1:0]   result,
    output logic [39:0]             mul_a,
    output logic [39:0]             mul_b,
    output logic                    mul_vld,
    input  logic [79:0]             mul_p
);

    localparam int OW = NLIMB * 40;
    localparam int RW = 2 * OW;
    localparam int IW = $clog2(NLIMB);
    localparam int KW = $clog2(2 * NLIMB);
    localparam int CW = $clog2(MUL_LAT) + 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NLIMB - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [OW-1:0]      a_q, a_d;
    logic [OW-1:0]      b_q, b_d;
    logic [IW-1:0]      i_q, i_d;
    logic [IW-1:0]      j_q, j_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [KW-1:0]      tag_k_q [MUL_LAT];
    logic [KW-1:0]      tag_k_d [MUL_LAT];
    logic [RW-1:0]      acc_q, acc_d;
    logic [RW-1:0]      result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // The multiplier port is combinational from the limb counters, so a pair
    // presented in cycle c returns on mul_p in cycle c+MUL_LAT, exactly when
    // its tag reaches the last shift-register stage.
    assign mul_a   = a_q[40*int'(i_q) +: 40];
    assign mul_b   = b_q[40*int'(j_q) +: 40];
    assign mul_vld = (state_q == S_ISSUE);
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        j_d       = j_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        acc_d     = acc_q;

        tag_vld_d[0] = (state_q == S_ISSUE);
        tag_k_d[0]   = KW'(i_q) + KW'(j_q);
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_k_d[s]   = tag_k_q[s-1];
        end

        if (tag_vld_q[MUL_LAT-1]) begin
            acc_d = acc_q + (RW'(mul_p) << (40 * int'(tag_k_q[MUL_LAT-1])));
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Counters park on the last pair so mul_a/mul_b hold through DRAIN.
                if (j_q == LAST_IDX) begin
                    if (i_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        i_d = i_q + 1'b1;
                        j_d = '0;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            cnt_q     <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_k_q[s] <= '0;
            end
            acc_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            i_q       <= i_d;
            j_q       <= j_d;
            cnt_q     <= cnt_d;
            tag_vld_q <= tag_vld_d;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_k_q[s] <= tag_k_d[s];
            end
            acc_q     <= acc_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_limb_mul_sched_40.sv
// tb/tb_limb_mul_sched_40.sv - self-checking bench for limb_mul_sched_40
module tb_limb_mul_sched_40;

    localparam int NLIMB   = 4;
    localparam int MUL_LAT = 2;
    localparam int OW      = NLIMB * 40;
    localparam int RW      = 2 * OW;
    localparam int LAT_EXP = NLIMB * NLIMB + MUL_LAT + 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [OW-1:0]   op_a;
    logic [OW-1:0]   op_b;
    logic            busy;
    logic            done;
    logic [RW-1:0]   result;
    logic [39:0]     mul_a;
    logic [39:0]     mul_b;
    logic            mul_vld;
    logic [79:0]     mul_p;

    limb_mul_sched_40 #(.NLIMB(NLIMB), .MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_vld (mul_vld),
        .mul_p   (mul_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: fixed latency, junk on idle slots, never reset.
    logic [79:0] pp [MUL_LAT];
    always @(posedge clk) begin
        pp[0] <= mul_vld ? (80'(mul_a) * 80'(mul_b)) : 80'({$urandom, $urandom, $urandom});
        for (int s = 1; s < MUL_LAT; s++) pp[s] <= pp[s-1];
    end
    assign mul_p = pp[MUL_LAT-1];

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    logic [39:0] qa[$];
    logic [39:0] qb[$];
    int          done_cyc[$];
    always @(negedge clk) begin
        if (mul_vld) begin
            qa.push_back(mul_a);
            qb.push_back(mul_b);
        end
        if (done) done_cyc.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] ref_mul(input logic [OW-1:0] a, input logic [OW-1:0] b);
        return RW'(a) * RW'(b);
    endfunction

    function automatic logic [OW-1:0] rnd_op();
        logic [OW-1:0] v;
        for (int w = 0; w < OW / 32; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    // Starts now (caller is away from the edge); returns #1 after the done edge.
    task automatic run_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input int inject,
                          output logic [RW-1:0] res, output int lat);
        qa.delete();
        qb.delete();
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", RW'(busy), RW'(1));
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == inject) begin
                start = 1'b1;
                op_a  = rnd_op();
                op_b  = rnd_op();
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        if (lat == 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done within 200 cycles");
        end
        res = result;
    endtask

    task automatic check_seq(input logic [OW-1:0] a, input logic [OW-1:0] b);
        bit ok = (qa.size() == NLIMB * NLIMB) && (qb.size() == NLIMB * NLIMB);
        if (ok) begin
            for (int n = 0; n < NLIMB * NLIMB; n++) begin
                if (qa[n] !== a[40*(n/NLIMB) +: 40] || qb[n] !== b[40*(n%NLIMB) +: 40]) ok = 0;
            end
        end
        check("issue_order", RW'(ok), RW'(1));
    endtask

    typedef struct {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic [RW-1:0] exp;
        int            inject;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t        v;
        logic [RW-1:0] res;
        logic [RW-1:0] ones_sq;
        logic [OW-1:0] ra;
        int          lat;

        ones_sq = '0;
        ones_sq = ones_sq - (RW'(1) << 161) + RW'(1);
        vecs.push_back('{a: OW'(1), b: OW'(1), exp: RW'(1), inject: 0});
        vecs.push_back('{a: '1, b: '1, exp: ones_sq, inject: 0});
        vecs.push_back('{a: OW'(1) << 120, b: (OW'(1) << 40) + OW'(5),
                         exp: (RW'(1) << 160) + (RW'(5) << 120), inject: 0});
        vecs.push_back('{a: '0, b: rnd_op(), exp: '0, inject: 5});
        for (int r = 0; r < 6; r++) begin
            v.a = rnd_op();
            v.b = rnd_op();
            if (r == 2) v.b[OW-1 -: 80] = '0;
            v.exp    = ref_mul(v.a, v.b);
            v.inject = (r == 4) ? 7 : 0;
            vecs.push_back(v);
        end

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #1;
        check("reset_outputs", RW'({busy, done, mul_vld, mul_a, mul_b}), '0);
        check("reset_result", result, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[n]) begin
            run_op(vecs[n].a, vecs[n].b, vecs[n].inject, res, lat);
            check($sformatf("result[%0d]", n), res, vecs[n].exp);
            check($sformatf("latency[%0d]", n), RW'(lat), RW'(LAT_EXP));
            check($sformatf("vld_cycles[%0d]", n), RW'(qa.size()), RW'(NLIMB * NLIMB));
            check($sformatf("busy_at_done[%0d]", n), RW'(busy), '0);
            check_seq(vecs[n].a, vecs[n].b);
            @(posedge clk);
            #1;
            check($sformatf("done_pulse[%0d]", n), RW'(done), '0);
            check($sformatf("result_held[%0d]", n), result, vecs[n].exp);
            @(negedge clk);
        end

        // Reset in the middle of an operation.
        ra    = rnd_op();
        op_a  = ra;
        op_b  = rnd_op();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs", RW'({busy, done, mul_vld, mul_a, mul_b}), '0);
        check("midop_reset_result", result, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(OW'(3), OW'(7), 0, res, lat);
        check("after_reset_result", res, RW'(21));
        check("after_reset_latency", RW'(lat), RW'(LAT_EXP));

        // Back-to-back: second start issued in the done cycle of the first.
        @(negedge clk);
        done_cyc.delete();
        run_op(OW'(123), OW'(456), 0, res, lat);
        check("b2b_first", res, RW'(56088));
        run_op(OW'(789), OW'(1011), 0, res, lat);
        check("b2b_second", res, RW'(797679));
        check("b2b_latency", RW'(lat), RW'(LAT_EXP));
        if (done_cyc.size() == 2) begin
            check("b2b_spacing", RW'(done_cyc[1] - done_cyc[0]), RW'(LAT_EXP + 1));
        end else begin
            check("b2b_done_count", RW'(done_cyc.size()), RW'(2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
